// File: rtl/bus_mem_responder.sv
// Memory-side responder for the BIU: wait-stated synchronous RAM with a four-phase req/ready handshake.
// Optional write protection of the low address range is enabled by defining BUS_MEM_ROM_PROTECT_EN.
module bus_mem_responder #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 'h0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_Address_Data_Bus,
    input  logic [DATA_W-1:0] i_DataOut_Bus,
    input  logic              W_R,
    input  logic              i_Req,
    output logic [DATA_W-1:0] o_DataRead_Bus,
    output logic              o_Ready,
    output logic              o_Busy,
    output logic              o_Error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              prot_hit;
    logic              mem_we;
    logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef BUS_MEM_ROM_PROTECT_EN
    assign prot_hit = wr_q && (addr_q <= ROM_TOP);
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign prot_hit       = 1'b0;
`endif

    // Gated by reset so an access aborted by reset in WAIT never reaches the RAM.
    assign mem_we = reset && (state == S_WAIT) && (count == 4'd0) && wr_q && !prot_hit;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            count          <= 4'd0;
            o_Ready        <= 1'b0;
            o_Busy         <= 1'b0;
            o_Error        <= 1'b0;
            o_DataRead_Bus <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Req) begin
                        addr_q  <= i_Address_Data_Bus;
                        wdata_q <= i_DataOut_Bus;
                        wr_q    <= W_R;
                        count   <= 4'(WAIT_CYCLES);
                        o_Busy  <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!wr_q) begin
                            o_DataRead_Bus <= mem[addr_q];
                        end
                        o_Ready <= 1'b1;
                        o_Error <= prot_hit;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Return to IDLE only; a new request is taken on a later edge.
                    if (!i_Req) begin
                        o_Ready <= 1'b0;
                        o_Error <= 1'b0;
                        o_Busy  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    o_Ready <= 1'b0;
                    o_Error <= 1'b0;
                    o_Busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: three instances (WAIT_CYCLES 1, 0, 3) share one stimulus bus.
// Protected-write expectations follow BUS_MEM_ROM_PROTECT_EN.
module tb_bus_mem_responder;

    typedef struct {
        int         e0;
        logic       chk;
        logic       ne;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       wr = 1'b0;
    logic       req = 1'b0;
    logic [7:0] rdat [3];
    logic       rdy [3];
    logic       busy [3];
    logic       err [3];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        exp_t q[$];
        logic prev = 1'b0;

        bus_mem_responder #(.WAIT_CYCLES(W)) u_dut (
            .clk                (clk),
            .reset              (reset),
            .i_Address_Data_Bus (addr),
            .i_DataOut_Bus      (wdata),
            .W_R                (wr),
            .i_Req              (req),
            .o_DataRead_Bus     (rdat[g]),
            .o_Ready            (rdy[g]),
            .o_Busy             (busy[g]),
            .o_Error            (err[g])
        );

        // Monitor: pops one expectation per rising o_Ready, sampled just after the edge.
        always begin
            exp_t it;
            @(posedge clk);
            #1;
            if (!reset) begin
                prev = 1'b0;
            end else begin
                if (rdy[g] && !prev) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_ready dut%0d: got ready at cycle %0d, expected none", g, cyc);
                    end else begin
                        it = q.pop_front();
                        check_output($sformatf("latency dut%0d", g), 32'(cyc - it.e0), 32'(1 + W));
                        check_output($sformatf("busy_at_ready dut%0d", g), 32'(busy[g]), 32'd1);
                        check_output($sformatf("error dut%0d", g), 32'(err[g]), 32'(it.err));
                        if (it.chk && !it.ne) begin
                            check_output($sformatf("read_data dut%0d", g), 32'(rdat[g]), 32'(it.data));
                        end else if (it.chk) begin
                            n_tests++;
                            if (rdat[g] === it.data) begin
                                n_fail++;
                                $display("[TB] FAIL read_protected dut%0d: got %0h, expected anything but %0h",
                                         g, rdat[g], it.data);
                            end
                        end
                    end
                end else if (!rdy[g] && q.size() > 0 && cyc >= q[0].e0) begin
                    check_output($sformatf("busy_in_wait dut%0d", g), 32'(busy[g]), 32'd1);
                end
                prev = rdy[g];
            end
        end
    end

    task automatic apply_stimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                                  input logic chk, input logic ne, input logic [7:0] exp_d,
                                  input logic exp_e, input int hold, input logic perturb);
        exp_t it;
        int   n;
        @(negedge clk);
        wr    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        it.e0   = cyc + 1;
        it.chk  = chk;
        it.ne   = ne;
        it.data = exp_d;
        it.err  = exp_e;
        g_dut[0].q.push_back(it);
        g_dut[1].q.push_back(it);
        g_dut[2].q.push_back(it);
        if (perturb) begin
            @(negedge clk);
            addr  = ~a;
            wdata = ~d;
            wr    = ~w;
        end
        n = 0;
        while ((g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL timeout: got no ready after %0d cycles, expected ready", n);
            g_dut[0].q.delete();
            g_dut[1].q.delete();
            g_dut[2].q.delete();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("ready_hold dut0", 32'(rdy[0]), 32'd1);
            check_output("ready_hold dut2", 32'(rdy[2]), 32'd1);
        end
        req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("idle_busy dut%0d", i), 32'(busy[i]), 32'd0);
            check_output($sformatf("idle_ready dut%0d", i), 32'(rdy[i]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for two edges with a pending request.
        reset = 1'b0;
        req   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_ready dut%0d", i), 32'(rdy[i]), 32'd0);
            check_output($sformatf("reset_busy dut%0d", i), 32'(busy[i]), 32'd0);
        end
        check_output("reset_data", 32'(rdat[0]), 32'h00);
        check_output("reset_error", 32'(err[0]), 32'd0);
        reset = 1'b1;
        req   = 1'b0;

        apply_stimulus(1'b1, 8'h06, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h07, 1'b0, 0, 1'b0);

        apply_stimulus(1'b1, 8'hBE, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        check_output("data_held_after_write", 32'(rdat[0]), 32'h07);
        apply_stimulus(1'b1, 8'h41, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 5, 1'b1);
        apply_stimulus(1'b0, 8'hBE, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 8'h41, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 5, 1'b1);

        // Aborted write: reset lands on the first WAIT edge.
        apply_stimulus(1'b1, 8'h20, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        @(negedge clk);
        wr    = 1'b1;
        addr  = 8'h20;
        wdata = 8'hAA;
        req   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("abort_ready dut0", 32'(rdy[0]), 32'd0);
            check_output("abort_busy dut2", 32'(busy[2]), 32'd0);
        end
        apply_stimulus(1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 0, 1'b0);

`ifdef BUS_MEM_ROM_PROTECT_EN
        apply_stimulus(1'b1, 8'h03, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        apply_stimulus(1'b0, 8'h03, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 0, 1'b0);
`else
        apply_stimulus(1'b1, 8'h03, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 0, 1'b0);
`endif
        apply_stimulus(1'b1, 8'h10, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h66, 1'b0, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the processor bus interface unit (BIU): accepts an address, write data and a write/read strobe driven by the BIU, performs the access on an internal synchronous RAM after a programmable number of wait states, and returns read data with a four-phase request/ready handshake. It sits on the far side of the BIU's address/data and data-out buses and acts as system memory for the 8-bit core.

## Interface
Parameters:
- ADDR_W, 8, address width; memory depth is 2^ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_CYCLES, 1, wait states inserted before each access; legal range 0..15.
- ROM_TOP, 8'h0F, highest protected address; used only when BUS_MEM_ROM_PROTECT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk, asserted when 0.
- i_Address_Data_Bus  in  ADDR_W  access address from the BIU.
- i_DataOut_Bus  in  DATA_W  write data from the BIU.
- W_R  in  1  access direction: 1 = write, 0 = read.
- i_Req  in  1  access request, level-sensitive, four-phase.
- o_DataRead_Bus  out  DATA_W  read data; valid while o_Ready = 1 after a read.
- o_Ready  out  1  access complete; held until i_Req drops.
- o_Busy  out  1  1 whenever the FSM is not in IDLE.
- o_Error  out  1  protected-write flag, qualified by o_Ready.

## Operation
- States: IDLE, WAIT, RESP (2-bit encoded, all outputs registered).
- IDLE: on an edge with i_Req = 1, latch address, write data and W_R into internal registers, load wait counter with WAIT_CYCLES, go to WAIT. Bus inputs are ignored after the latch until the next IDLE.
- WAIT: counter != 0 -> decrement, stay. Counter == 0 -> perform access, set o_Ready = 1, go to RESP.
  - Write: mem[addr] <= wdata; o_DataRead_Bus unchanged.
  - Read: o_DataRead_Bus <= mem[addr].
- RESP: o_Ready held at 1 while i_Req = 1. On an edge with i_Req = 0: o_Ready <= 0, o_Error <= 0, go to IDLE. A new request is accepted no earlier than the following edge in IDLE (no back-to-back accept from RESP).
- i_Req falling while in WAIT: the access still completes; RESP sees i_Req = 0 on its first edge and returns to IDLE, so o_Ready is high for exactly one cycle.
- o_Busy = 1 in WAIT and RESP, 0 in IDLE.
- Address arithmetic: full ADDR_W decode, no wrap logic needed; every address maps to one word.

## Timing
- Reset (reset = 0 on an edge): state <= IDLE, o_Ready = 0, o_Busy = 0, o_Error = 0, o_DataRead_Bus = 0, counter = 0. RAM contents are not cleared. Reset mid-WAIT aborts the access with no memory write; reset mid-RESP drops o_Ready on that edge.
- Latency: i_Req sampled at edge E0 -> o_Ready high after edge E0 + 1 + WAIT_CYCLES. With WAIT_CYCLES = 0 that is the second edge; with the default of 1, the third edge.
- Read data is valid in the same cycle that o_Ready rises and stays stable until the next read completes.
- The write commits on the same edge that raises o_Ready.

## Configuration
- BUS_MEM_ROM_PROTECT_EN defined: writes to addresses <= ROM_TOP are suppressed (the RAM is unchanged), still complete the handshake normally, and set o_Error = 1 together with o_Ready. Reads from the protected range behave normally.
- Undefined: every address is writable, and o_Error is tied to 0.

## Test plan
- Reset: hold reset = 0 for 2 edges with i_Req = 1 -> o_Ready = 0, o_Busy = 0, o_DataRead_Bus = 8'h00, state IDLE.
- Write then read, WAIT_CYCLES = 1: write 8'h07 to 8'h06 (W_R = 1), then read 8'h06 (W_R = 0) -> o_Ready rises at E0 + 2 both times; the read returns 8'h07.
- Latency sweep: WAIT_CYCLES = 0 and WAIT_CYCLES = 3 -> o_Ready rises at E0 + 1 and E0 + 4 respectively; o_Busy is high for the whole interval.
- Handshake hold: keep i_Req = 1 for 5 cycles after o_Ready rises -> o_Ready stays 1 and no second access occurs; drop i_Req -> IDLE on the next edge. Change the address during WAIT -> the latched address is still used.
- Reset mid-access: write 8'hAA to 8'h20, asserting reset during WAIT -> o_Ready never rises; a later read of 8'h20 returns its prior value.
- BUS_MEM_ROM_PROTECT_EN with ROM_TOP = 8'h0F: write 8'h55 to 8'h03 -> o_Ready = 1, o_Error = 1, and a read of 8'h03 returns the old value. Write to 8'h10 -> o_Error = 0 and the value is stored.
